// File: rtl/mem_wb_pipe.sv
// MEM->WB pipeline register with valid/ready on both sides.
// A main (head) entry plus a skid entry lets in_ready_o come straight from a flop at full throughput.
module mem_wb_pipe #(
  parameter int DATA_W        = 32,
  parameter int ADDR_W        = 5,
  parameter int ZERO_SUPPRESS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_op_c_i,
  input  logic [ADDR_W-1:0] in_reg_waddr_i,
  input  logic              in_reg_we_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_op_c_o,
  output logic [ADDR_W-1:0] out_reg_waddr_o,
  output logic              out_reg_we_o
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  localparam logic ZS_EN = (ZERO_SUPPRESS != 0);

  logic [1:0]        state_q, state_d;
  logic              in_ready_q, out_valid_q;

  logic [DATA_W-1:0] main_op_c_q, skid_op_c_q;
  logic [ADDR_W-1:0] main_waddr_q, skid_waddr_q;
  logic              main_we_q, skid_we_q;

  logic              accept, pop;
  logic              in_we_eff;
  logic              load_main_in, load_main_skid, load_skid_in;

  assign accept = in_valid_i & in_ready_q;
  assign pop    = out_valid_q & out_ready_i;

  // Writes to x0 are dropped at capture so the register file never sees them.
  assign in_we_eff = in_reg_we_i & ~(ZS_EN & (in_reg_waddr_i == '0));

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid_in   = 1'b0;
    unique case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          load_main_in = 1'b1;
          state_d      = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && pop) begin
          load_main_in = 1'b1;
        end else if (accept) begin
          load_skid_in = 1'b1;
          state_d      = ST_TWO;
        end else if (pop) begin
          state_d      = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (pop) begin
          load_main_skid = 1'b1;
          state_d        = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Flush overrides any same-cycle accept or pop; stale payload is masked by out_valid_o.
    if (flush_i) begin
      state_d        = ST_EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid_in   = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != ST_TWO);
      out_valid_q <= (state_d != ST_EMPTY);
    end
  end

  // NOTE: payload regs are reset too, so outputs read zero after reset rather than X.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_op_c_q  <= '0;
      main_waddr_q <= '0;
      main_we_q    <= 1'b0;
      skid_op_c_q  <= '0;
      skid_waddr_q <= '0;
      skid_we_q    <= 1'b0;
    end else begin
      if (load_main_in) begin
        main_op_c_q  <= in_op_c_i;
        main_waddr_q <= in_reg_waddr_i;
        main_we_q    <= in_we_eff;
      end else if (load_main_skid) begin
        main_op_c_q  <= skid_op_c_q;
        main_waddr_q <= skid_waddr_q;
        main_we_q    <= skid_we_q;
      end
      if (load_skid_in) begin
        skid_op_c_q  <= in_op_c_i;
        skid_waddr_q <= in_reg_waddr_i;
        skid_we_q    <= in_we_eff;
      end
    end
  end

  assign in_ready_o      = in_ready_q;
  assign out_valid_o     = out_valid_q;
  assign out_op_c_o      = main_op_c_q;
  assign out_reg_waddr_o = main_waddr_q;
  assign out_reg_we_o    = main_we_q & out_valid_q;

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Directed and randomised checks for mem_wb_pipe: default, no-x0-suppress and 64-bit instances.
module tb_mem_wb_pipe;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_we, out_ready;
  logic [31:0] in_op_c;
  logic [63:0] in_op_c_w;
  logic [4:0]  in_waddr;

  logic        a_in_ready, a_out_valid, a_out_we;
  logic [31:0] a_out_op_c;
  logic [4:0]  a_out_waddr;
  logic        b_in_ready, b_out_valid, b_out_we;
  logic [31:0] b_out_op_c;
  logic [4:0]  b_out_waddr;
  logic        w_in_ready, w_out_valid, w_out_we;
  logic [63:0] w_out_op_c;
  logic [4:0]  w_out_waddr;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_wb_pipe dut (
    .clk(clk), .rst(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(a_in_ready),
    .in_op_c_i(in_op_c), .in_reg_waddr_i(in_waddr), .in_reg_we_i(in_we),
    .out_valid_o(a_out_valid), .out_ready_i(out_ready), .out_op_c_o(a_out_op_c),
    .out_reg_waddr_o(a_out_waddr), .out_reg_we_o(a_out_we)
  );

  mem_wb_pipe #(.ZERO_SUPPRESS(0)) dut_nz (
    .clk(clk), .rst(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(b_in_ready),
    .in_op_c_i(in_op_c), .in_reg_waddr_i(in_waddr), .in_reg_we_i(in_we),
    .out_valid_o(b_out_valid), .out_ready_i(out_ready), .out_op_c_o(b_out_op_c),
    .out_reg_waddr_o(b_out_waddr), .out_reg_we_o(b_out_we)
  );

  mem_wb_pipe #(.DATA_W(64)) dut_w (
    .clk(clk), .rst(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(w_in_ready),
    .in_op_c_i(in_op_c_w), .in_reg_waddr_i(in_waddr), .in_reg_we_i(in_we),
    .out_valid_o(w_out_valid), .out_ready_i(out_ready), .out_op_c_o(w_out_op_c),
    .out_reg_waddr_o(w_out_waddr), .out_reg_we_o(w_out_we)
  );

  // Advance one rising edge, then settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_we = 1'b1; out_ready = 1'b0;
    in_op_c = '0; in_op_c_w = '0; in_waddr = 5'd1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1; in_valid = 1'b1; in_op_c = 32'hCAFE_0001; out_ready = 1'b0;
    step();
    rst = 1'b0; in_valid = 1'b0;
    checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", a_out_valid); end
    checks++; if (a_out_we !== 1'b0) begin failures++; $display("FAIL reset_we got=%b exp=0", a_out_we); end
    checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", a_in_ready); end
    checks++; if (a_out_op_c !== 32'h0) begin failures++; $display("FAIL reset_op_c got=%h exp=0", a_out_op_c); end
    checks++; if (a_out_waddr !== 5'h0) begin failures++; $display("FAIL reset_waddr got=%h exp=0", a_out_waddr); end
    step();
    checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL reset_nocapture got=%b exp=0", a_out_valid); end
  endtask

  task automatic test_streaming();
    logic [31:0] vals [3] = '{32'h11, 32'h22, 32'h33};
    idle_inputs();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_op_c = vals[i]; in_waddr = 5'(i + 3);
      step();
      checks++; if (a_out_valid !== 1'b1 || a_out_op_c !== vals[i])
        begin failures++; $display("FAIL stream_data[%0d] got=%b/%h exp=1/%h", i, a_out_valid, a_out_op_c, vals[i]); end
      checks++; if (a_out_waddr !== 5'(i + 3) || a_out_we !== 1'b1)
        begin failures++; $display("FAIL stream_waddr[%0d] got=%h/%b exp=%h/1", i, a_out_waddr, a_out_we, 5'(i + 3)); end
      checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL stream_ready[%0d] got=%b exp=1", i, a_in_ready); end
    end
    in_valid = 1'b0;
    step();
    checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL stream_drain got=%b exp=0", a_out_valid); end
  endtask

  task automatic test_backpressure();
    idle_inputs();
    out_ready = 1'b0;
    in_valid = 1'b1; in_op_c = 32'hA1;
    step();
    checks++; if (a_in_ready !== 1'b1 || a_out_op_c !== 32'hA1)
      begin failures++; $display("FAIL bp_first got=%b/%h exp=1/a1", a_in_ready, a_out_op_c); end
    in_op_c = 32'hA2;
    step();
    checks++; if (a_in_ready !== 1'b0) begin failures++; $display("FAIL bp_full_ready got=%b exp=0", a_in_ready); end
    in_op_c = 32'hA3;
    step();
    checks++; if (a_in_ready !== 1'b0 || a_out_valid !== 1'b1 || a_out_op_c !== 32'hA1)
      begin failures++; $display("FAIL bp_hold got=%b/%b/%h exp=0/1/a1", a_in_ready, a_out_valid, a_out_op_c); end
    out_ready = 1'b1;
    step();
    checks++; if (a_out_op_c !== 32'hA2 || a_in_ready !== 1'b1)
      begin failures++; $display("FAIL bp_order2 got=%h/%b exp=a2/1", a_out_op_c, a_in_ready); end
    step();
    checks++; if (a_out_op_c !== 32'hA3 || a_out_valid !== 1'b1)
      begin failures++; $display("FAIL bp_order3 got=%h/%b exp=a3/1", a_out_op_c, a_out_valid); end
    in_valid = 1'b0;
    step();
    checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL bp_nodup got=%b exp=0", a_out_valid); end
  endtask

  task automatic test_flush();
    idle_inputs();
    in_valid = 1'b1; in_op_c = 32'hB1;
    step();
    in_op_c = 32'hB2;
    step();
    checks++; if (a_in_ready !== 1'b0) begin failures++; $display("FAIL flush_setup got=%b exp=0", a_in_ready); end
    flush = 1'b1; out_ready = 1'b1; in_op_c = 32'hB3;
    step();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_out_we !== 1'b0)
      begin failures++; $display("FAIL flush_empty got=%b/%b/%b exp=0/1/0", a_out_valid, a_in_ready, a_out_we); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL flush_reappear[%0d] got=%b exp=0", i, a_out_valid); end
    end
  endtask

  task automatic test_zero_suppress();
    idle_inputs();
    in_valid = 1'b1; in_we = 1'b1; in_waddr = 5'd0; in_op_c = 32'hDEAD_BEEF;
    step();
    checks++; if (a_out_we !== 1'b0 || a_out_op_c !== 32'hDEAD_BEEF)
      begin failures++; $display("FAIL x0_suppressed got=%b/%h exp=0/deadbeef", a_out_we, a_out_op_c); end
    checks++; if (b_out_we !== 1'b1 || b_out_waddr !== 5'd0)
      begin failures++; $display("FAIL x0_passthrough got=%b/%h exp=1/0", b_out_we, b_out_waddr); end
    out_ready = 1'b1; in_waddr = 5'd5; in_op_c = 32'h0000_0055;
    step();
    checks++; if (a_out_we !== 1'b1 || a_out_waddr !== 5'd5)
      begin failures++; $display("FAIL x5_we_default got=%b/%h exp=1/5", a_out_we, a_out_waddr); end
    checks++; if (b_out_we !== 1'b1) begin failures++; $display("FAIL x5_we_nz got=%b exp=1", b_out_we); end
    in_valid = 1'b0;
    step();
    checks++; if (a_out_we !== 1'b0 || b_out_we !== 1'b0)
      begin failures++; $display("FAIL we_when_invalid got=%b/%b exp=0/0", a_out_we, b_out_we); end
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    in_valid = 1'b1; in_op_c = 32'hC1;
    step();
    in_op_c = 32'hC2;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0; in_valid = 1'b0;
    checks++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_out_op_c !== 32'h0)
      begin failures++; $display("FAIL reset_mid got=%b/%b/%h exp=0/1/0", a_out_valid, a_in_ready, a_out_op_c); end
  endtask

  task automatic test_random();
    logic [63:0] q [$];
    logic [63:0] pend;
    bit          pend_v;
    logic        acc, pop, rdy_before;
    idle_inputs();
    pend = '0; pend_v = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!pend_v && $urandom_range(0, 3) != 0) begin
        pend = {$urandom, $urandom}; pend_v = 1'b1;
      end
      in_valid = pend_v; in_op_c_w = pend;
      out_ready = 1'($urandom_range(0, 1));
      #1;
      checks++; if (w_out_valid !== (q.size() != 0) || w_in_ready !== (q.size() != 2))
        begin failures++; $display("FAIL rand_occ[%0d] got=%b/%b depth=%0d", c, w_out_valid, w_in_ready, q.size()); end
      rdy_before = w_in_ready;
      out_ready = ~out_ready;
      #1;
      checks++; if (w_in_ready !== rdy_before)
        begin failures++; $display("FAIL rand_ready_comb[%0d] got=%b exp=%b", c, w_in_ready, rdy_before); end
      out_ready = ~out_ready;
      #1;
      acc = in_valid & w_in_ready;
      pop = w_out_valid & out_ready;
      if (pop && q.size() != 0) begin
        checks++; if (w_out_op_c !== q[0])
          begin failures++; $display("FAIL rand_data[%0d] got=%h exp=%h", c, w_out_op_c, q[0]); end
      end
      step();
      if (pop && q.size() != 0) void'(q.pop_front());
      if (acc) begin q.push_back(pend); pend_v = 1'b0; end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 8 && q.size() != 0; c++) begin
      checks++; if (w_out_valid !== 1'b1 || w_out_op_c !== q[0])
        begin failures++; $display("FAIL rand_drain[%0d] got=%b/%h exp=1/%h", c, w_out_valid, w_out_op_c, q[0]); end
      step();
      void'(q.pop_front());
    end
    checks++; if (q.size() != 0 || w_out_valid !== 1'b0)
      begin failures++; $display("FAIL rand_final got=%b left=%0d exp=0/0", w_out_valid, q.size()); end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_zero_suppress();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
